// File: rtl/front_spi_pkg.sv
// Shared types and constants for the front-panel SPI master.
package front_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } spi_state_e;

  // SPI mode encodings {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE_0 = 2'b00;
  localparam logic [1:0] SPI_MODE_1 = 2'b01;
  localparam logic [1:0] SPI_MODE_2 = 2'b10;
  localparam logic [1:0] SPI_MODE_3 = 2'b11;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: toggles SCLK every CLK_DIV cycles while enabled and flags
// whether the coming toggle is the leading or trailing edge.
module spi_sclk_gen #(
  parameter int unsigned CLK_DIV = 4,
  parameter bit          CPOL    = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic en,
  output logic sclk,
  output logic lead,
  output logic trail
);

  localparam int unsigned DW       = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;
  logic          tc;

  assign tc    = en && (div == '0);
  assign lead  = tc && (sclk == CPOL);
  assign trail = tc && (sclk != CPOL);

  // Divider sits at its load value whenever disabled so every frame starts aligned.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      div  <= DIV_LOAD;
      sclk <= CPOL;
    end else if (!en) begin
      div  <= DIV_LOAD;
      sclk <= CPOL;
    end else if (tc) begin
      div  <= DIV_LOAD;
      sclk <= ~sclk;
    end else begin
      div  <= div - DW'(1);
    end
  end

endmodule

// File: rtl/front_spi_master.sv
// Single-chip-select full-duplex SPI master; one MSB-first frame per start edge.
module front_spi_master
  import front_spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 24,
  parameter int unsigned CLK_DIV      = 4,
  parameter bit          CPOL         = 1'b0,
  parameter bit          CPHA         = 1'b0,
  parameter int unsigned CS_SETUP_CYC = 2,
  parameter int unsigned CS_HOLD_CYC  = 2,
  parameter int unsigned CS_GAP_CYC   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_spi_start,
  input  logic [DATA_WIDTH-1:0] i_mosi_data,
  output logic [DATA_WIDTH-1:0] o_miso_data,
  output logic                  o_spi_done,
  output logic                  o_spi_busy,
  output logic                  n_cs,
  output logic                  o_sclk,
  output logic                  o_mosi,
  input  logic                  i_miso
);

  localparam int unsigned EW = $clog2(2 * DATA_WIDTH + 1);
  localparam int unsigned CW = $clog2(max3(CS_SETUP_CYC, CS_HOLD_CYC, CS_GAP_CYC) + 1);
  localparam logic [EW-1:0] LAST_EDGE  = EW'(2 * DATA_WIDTH - 1);
  localparam logic [CW-1:0] SETUP_LOAD = CW'(CS_SETUP_CYC - 1);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(CS_HOLD_CYC - 1);
  localparam logic [CW-1:0] GAP_LOAD   = (CS_GAP_CYC == 0) ? '0 : CW'(CS_GAP_CYC - 1);

  spi_state_e state, state_nxt;

  logic                  start_q, start_q2, accept;
  logic [CW-1:0]         cyc_cnt;
  logic                  cyc_zero;
  logic [EW-1:0]         edge_cnt;
  logic                  last_edge;
  logic [DATA_WIDTH-1:0] shreg, rxreg;
  logic                  miso_q;
  logic                  lead, trail, do_shift, do_sample, hold_exit;

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV),
    .CPOL    (CPOL)
  ) u_sclk (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .en    (state == SHIFT),
    .sclk  (o_sclk),
    .lead  (lead),
    .trail (trail)
  );

  assign accept    = start_q && !start_q2 && (state == IDLE);
  assign cyc_zero  = (cyc_cnt == '0);
  assign last_edge = (edge_cnt == LAST_EDGE);
  assign do_sample = CPHA ? trail : lead;
  assign do_shift  = CPHA ? lead : (trail && !last_edge);
  assign hold_exit = (state == HOLD) && (state_nxt != HOLD);

  always_ff @(posedge i_clk) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   if (cyc_zero) state_nxt = SHIFT;
      SHIFT:   if ((lead || trail) && last_edge) state_nxt = HOLD;
      HOLD:    if (cyc_zero) state_nxt = (CS_GAP_CYC == 0) ? IDLE : GAP;
      GAP:     if (cyc_zero) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Phase counter reloads on every state entry and counts down to the exit cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cyc_cnt <= '0;
    end else if (state_nxt != state) begin
      case (state_nxt)
        SETUP:   cyc_cnt <= SETUP_LOAD;
        HOLD:    cyc_cnt <= HOLD_LOAD;
        GAP:     cyc_cnt <= GAP_LOAD;
        default: cyc_cnt <= '0;
      endcase
    end else if (!cyc_zero) begin
      cyc_cnt <= cyc_cnt - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      start_q  <= 1'b0;
      start_q2 <= 1'b0;
      miso_q   <= 1'b0;
    end else begin
      start_q  <= i_spi_start;
      start_q2 <= start_q;
      miso_q   <= i_miso;
    end
  end

  // CPHA=0 presents the MSB at accept; CPHA=1 drives each bit on its leading edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      shreg    <= '0;
      rxreg    <= '0;
      edge_cnt <= '0;
      o_mosi   <= 1'b0;
    end else if (accept) begin
      shreg    <= CPHA ? i_mosi_data : (i_mosi_data << 1);
      o_mosi   <= CPHA ? 1'b0 : i_mosi_data[DATA_WIDTH-1];
      rxreg    <= '0;
      edge_cnt <= '0;
    end else if (state == SHIFT) begin
      if (lead || trail) edge_cnt <= edge_cnt + EW'(1);
      if (do_shift) begin
        o_mosi <= shreg[DATA_WIDTH-1];
        shreg  <= {shreg[DATA_WIDTH-2:0], 1'b0};
      end
      if (do_sample) rxreg <= {rxreg[DATA_WIDTH-2:0], miso_q};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      n_cs        <= 1'b1;
      o_spi_busy  <= 1'b0;
      o_spi_done  <= 1'b0;
      o_miso_data <= '0;
    end else begin
      n_cs       <= !(state_nxt inside {SETUP, SHIFT, HOLD});
      o_spi_busy <= (state_nxt != IDLE);
      o_spi_done <= hold_exit;
      if (hold_exit) o_miso_data <= rxreg;
    end
  end

endmodule

// File: tb/tb_front_spi_master.sv
// Bench for front_spi_master: mode-0 loopback instance and mode-3 instance with a slave model.
module tb_front_spi_master;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start0 = 1'b0, start3 = 1'b0;
  logic [23:0] data0 = '0, data3 = '0;
  logic [23:0] rx0, rx3;
  logic        done0, busy0, ncs0, sclk0, mosi0, miso0;
  logic        done3, busy3, ncs3, sclk3, mosi3;
  logic        miso3 = 1'b0;

  assign miso0 = mosi0;

  front_spi_master #(
    .DATA_WIDTH(24), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0),
    .CS_SETUP_CYC(1), .CS_HOLD_CYC(1), .CS_GAP_CYC(4)
  ) dut0 (
    .i_clk(clk), .i_rst(rst), .i_spi_start(start0), .i_mosi_data(data0),
    .o_miso_data(rx0), .o_spi_done(done0), .o_spi_busy(busy0), .n_cs(ncs0),
    .o_sclk(sclk0), .o_mosi(mosi0), .i_miso(miso0)
  );

  front_spi_master #(
    .DATA_WIDTH(24), .CLK_DIV(4), .CPOL(1'b1), .CPHA(1'b1),
    .CS_SETUP_CYC(2), .CS_HOLD_CYC(2), .CS_GAP_CYC(4)
  ) dut3 (
    .i_clk(clk), .i_rst(rst), .i_spi_start(start3), .i_mosi_data(data3),
    .o_miso_data(rx3), .o_spi_done(done3), .o_spi_busy(busy3), .n_cs(ncs3),
    .o_sclk(sclk3), .o_mosi(mosi3), .i_miso(miso3)
  );

  int nvec = 0, nerr = 0;
  int dones0 = 0, dones3 = 0, edges0 = 0;
  logic sclk0_d = 1'b0;
  logic [23:0] q0[$], q3rx[$], q3cap[$];
  logic [23:0] slv_tx = '0, slv_rx = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    nvec++;
    nerr++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  // Mode-3 slave: drive on falling (leading) edge, capture on rising (trailing) edge.
  always @(negedge sclk3) if (!ncs3) begin
    miso3  = slv_tx[23];
    slv_tx = slv_tx << 1;
  end
  always @(posedge sclk3) if (!ncs3) slv_rx = {slv_rx[22:0], mosi3};

  always @(negedge clk) begin
    if (sclk0 !== sclk0_d) edges0++;
    sclk0_d = sclk0;
    if (done0) begin
      dones0++;
      if (q0.size() == 0) check("sb0 unexpected done", 32'd1, 32'd0);
      else check("sb0 rx", {8'h0, rx0}, {8'h0, q0.pop_front()});
    end
    if (done3) begin
      dones3++;
      if (q3rx.size() == 0) check("sb3 unexpected done", 32'd1, 32'd0);
      else begin
        check("sb3 rx", {8'h0, rx3}, {8'h0, q3rx.pop_front()});
        check("sb3 slave cap", {8'h0, slv_rx}, {8'h0, q3cap.pop_front()});
      end
    end
  end

  task automatic wait_idle0();
    int n = 0;
    while (busy0 && n < 50) begin @(negedge clk); n++; end
    if (busy0) timeout("idle0");
  endtask

  task automatic run0(input logic [23:0] tx);
    int lat = 0, e = 0;
    bit seen = 0;
    @(negedge clk);
    data0 = tx;
    q0.push_back(tx);
    e = edges0;
    start0 = 1'b1;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (i == 1) start0 = 1'b0;
      if (i == 3) data0 = ~tx;
      if (done0) seen = 1;
    end
    if (!seen) timeout("run0 done");
    else begin
      check("lat0", lat - 1, 99);
      check("ncs0 at done", {31'h0, ncs0}, 1);
    end
    @(negedge clk);
    check("edges0", edges0 - e, 48);
    wait_idle0();
    check("sclk0 idle", {31'h0, sclk0}, 0);
  endtask

  task automatic run3(input logic [23:0] tx, input logic [23:0] reply);
    int lat = 0, n = 0;
    bit seen = 0;
    @(negedge clk);
    data3 = tx;
    slv_tx = reply;
    slv_rx = '0;
    q3rx.push_back(reply);
    q3cap.push_back(tx);
    start3 = 1'b1;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (i == 1) start3 = 1'b0;
      if (i == 3) data3 = ~tx;
      if (done3) seen = 1;
    end
    if (!seen) timeout("run3 done");
    else check("lat3", lat - 1, 197);
    while (busy3 && n < 50) begin @(negedge clk); n++; end
    if (busy3) timeout("idle3");
    check("sclk3 idle high", {31'h0, sclk3}, 1);
  endtask

  typedef struct {
    logic [23:0] tx;
    logic [23:0] reply;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int d, e, n;
    bit low_seen;
    vecs[0] = '{tx: 24'hA5C3F0, reply: 24'h5A0F81};
    vecs[1] = '{tx: 24'h123456, reply: 24'h5A0F81};
    vecs[2] = '{tx: 24'hFFFFFF, reply: 24'h000000};
    vecs[3] = '{tx: 24'h000000, reply: 24'hFFFFFF};
    vecs[4] = '{tx: 24'h800001, reply: 24'h7FFFFE};

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst ncs0", {31'h0, ncs0}, 1);
    check("rst sclk0", {31'h0, sclk0}, 0);
    check("rst sclk3", {31'h0, sclk3}, 1);
    check("rst rx0", {8'h0, rx0}, 0);
    check("rst busy0", {31'h0, busy0}, 0);
    check("rst done0", {31'h0, done0}, 0);
    check("rst mosi0", {31'h0, mosi0}, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run0(vecs[i].tx);
      run3(vecs[i].tx, vecs[i].reply);
    end

    // level held high launches exactly one frame
    @(negedge clk);
    d = dones0;
    data0 = 24'h3C3C3C;
    q0.push_back(24'h3C3C3C);
    start0 = 1'b1;
    repeat (500) @(negedge clk);
    start0 = 1'b0;
    wait_idle0();
    check("held dones", dones0 - d, 1);

    // edges mid-SHIFT, at done and in GAP are dropped
    @(negedge clk);
    d = dones0;
    data0 = 24'hC0FFEE;
    q0.push_back(24'hC0FFEE);
    start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    repeat (40) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    n = 0;
    while (!done0 && n < 200) begin @(negedge clk); n++; end
    if (!done0) timeout("ignore done");
    start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    low_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!ncs0) low_seen = 1;
    end
    check("gap ignore ncs", {31'h0, low_seen}, 0);
    check("ignore dones", dones0 - d, 1);
    wait_idle0();
    run0(24'h0F1E2D);
    check("after busy dones", dones0 - d, 2);

    // reset at bit 10 aborts the frame
    @(negedge clk);
    d = dones0;
    e = edges0;
    data0 = 24'hDEAD01;
    start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    n = 0;
    while ((edges0 - e) < 20 && n < 200) begin @(negedge clk); n++; end
    if ((edges0 - e) < 20) timeout("reset bit10");
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid rst ncs0", {31'h0, ncs0}, 1);
    check("mid rst rx0", {8'h0, rx0}, 0);
    check("mid rst busy0", {31'h0, busy0}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("mid rst no done", dones0 - d, 0);
    run0(24'h6B6B6B);

    check("sb0 drained", q0.size(), 0);
    check("sb3 drained", q3rx.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
